// File: rtl/bridge_timer_pkg.sv
// Shared constants for the bridge_timer slice.
// Holds register offsets, CTRL bit positions, the MemWrite word code and the
// per-timer FSM state encodings used by bridge_timer and timer_unit.
package bridge_timer_pkg;

    // Register offsets within a 16-byte timer window, selected by address bits [3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // Mode 01 reloads; 00 and 1x both behave as one-shot
    localparam logic [1:0] MODE_AUTO = 2'b01;

    // MemWrite code for a full-word store; only these reach the timers
    localparam logic [1:0] MEM_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_unit.sv
// One programmable count-down timer: CTRL/PRESET/COUNT registers, FSM, irq.
// Ports:
//   clk  system clock
//   clr  synchronous active-high reset
//   we   word write strobe, already qualified by address hit
//   sel  register select (address bits [3:2])
//   wd   write data
//   rd   read data for the selected register (combinational)
//   irq  interrupt request: IM & (pending | state == INT)
module timer_unit
    import bridge_timer_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    timer_state_e state_r;
    timer_state_e state_nx_s;
    logic        en_r;
    logic        en_nx_s;
    logic        fsm_en_s;
    logic [1:0]  mode_r;
    logic [1:0]  mode_nx_s;
    logic        im_r;
    logic        im_nx_s;
    logic        pend_r;
    logic        pend_nx_s;
    logic        fsm_pend_s;
    logic [31:0] preset_r;
    logic [31:0] preset_nx_s;
    logic [31:0] count_r;
    logic [31:0] count_nx_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;

    assign wr_ctrl_s   = we && (sel == REG_CTRL);
    assign wr_preset_s = we && (sel == REG_PRESET);

    // FSM next state and count; a zero PRESET or a count of 1 steps straight
    // into INT so that INT lands exactly PRESET cycles after the load.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        fsm_en_s   = en_r;
        fsm_pend_s = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (en_r) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!en_r) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    count_nx_s = preset_r;
                    if (preset_r == 32'd0) begin
                        state_nx_s = ST_INT;
                    end else begin
                        state_nx_s = ST_CNT;
                    end
                end
            end
            ST_CNT: begin
                if (!en_r) begin
                    state_nx_s = ST_IDLE;
                end else if (count_r <= 32'd1) begin
                    count_nx_s = 32'd0;
                    state_nx_s = ST_INT;
                end else begin
                    count_nx_s = count_r - 32'd1;
                    state_nx_s = ST_CNT;
                end
            end
            ST_INT: begin
                if (!en_r) begin
                    state_nx_s = ST_IDLE;
                end else if (mode_r == MODE_AUTO) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    fsm_pend_s = 1'b1;
                    fsm_en_s   = 1'b0;
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // CPU writes override the FSM's Enable/pending update; any CTRL or PRESET write clears pending
    always_comb begin
        en_nx_s     = fsm_en_s;
        mode_nx_s   = mode_r;
        im_nx_s     = im_r;
        pend_nx_s   = fsm_pend_s;
        preset_nx_s = preset_r;
        if (wr_ctrl_s) begin
            en_nx_s   = wd[CTRL_EN_BIT];
            mode_nx_s = wd[CTRL_MODE_MSB:CTRL_MODE_LSB];
            im_nx_s   = wd[CTRL_IM_BIT];
            pend_nx_s = 1'b0;
        end else if (wr_preset_s) begin
            preset_nx_s = wd;
            pend_nx_s   = 1'b0;
        end else begin
            pend_nx_s = fsm_pend_s;
        end
    end

    // Timer state registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= ST_IDLE;
            en_r     <= 1'b0;
            mode_r   <= 2'b00;
            im_r     <= 1'b0;
            pend_r   <= 1'b0;
            preset_r <= 32'd0;
            count_r  <= 32'd0;
        end else begin
            state_r  <= state_nx_s;
            en_r     <= en_nx_s;
            mode_r   <= mode_nx_s;
            im_r     <= im_nx_s;
            pend_r   <= pend_nx_s;
            preset_r <= preset_nx_s;
            count_r  <= count_nx_s;
        end
    end

    // Register read mux; the reserved slot reads as zero
    always_comb begin
        rd = 32'd0;
        case (sel)
            REG_CTRL:   rd = {28'd0, im_r, mode_r, en_r};
            REG_PRESET: rd = preset_r;
            REG_COUNT:  rd = count_r;
            default:    rd = 32'd0;
        endcase
    end

    assign irq = im_r & (pend_r | (state_r == ST_INT));

endmodule

// File: rtl/bridge_timer.sv
// Processor-bus responder holding two count-down timers.
// Ports:
//   clk       system clock
//   clr       synchronous active-high reset
//   PrAddr    CPU data address
//   PrWD      CPU store data
//   MemWrite  store size: 00 none, 01 byte, 10 half, 11 word
//   ext_int   external interrupt lines (passed through unsynchronised)
//   PrRD      read data, combinational from PrAddr
//   HWInt     {ext_int, irq1, irq0}
module bridge_timer
    import bridge_timer_pkg::*;
#(
    parameter logic [31:0] T0_BASE = 32'h0000_7F00,
    parameter logic [31:0] T1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic [1:0]  MemWrite,
    input  logic [3:0]  ext_int,
    output logic [31:0] PrRD,
    output logic [5:0]  HWInt
);

    logic        hit0_s;
    logic        hit1_s;
    logic        word_wr_s;
    logic [1:0]  sel_s;
    logic [31:0] rd0_s;
    logic [31:0] rd1_s;
    logic        irq0_s;
    logic        irq1_s;
    logic        addr_unused_s;

    assign hit0_s    = (PrAddr[31:4] == T0_BASE[31:4]);
    assign hit1_s    = (PrAddr[31:4] == T1_BASE[31:4]);
    assign word_wr_s = (MemWrite == MEM_WORD);
    assign sel_s     = PrAddr[3:2];

    // Registers are word-aligned; the byte offset carries no information here
    assign addr_unused_s = ^PrAddr[1:0];

    timer_unit u_timer0 (
        .clk (clk),
        .clr (clr),
        .we  (hit0_s && word_wr_s),
        .sel (sel_s),
        .wd  (PrWD),
        .rd  (rd0_s),
        .irq (irq0_s)
    );

    timer_unit u_timer1 (
        .clk (clk),
        .clr (clr),
        .we  (hit1_s && word_wr_s),
        .sel (sel_s),
        .wd  (PrWD),
        .rd  (rd1_s),
        .irq (irq1_s)
    );

    // Device read mux; unmapped addresses read as zero
    always_comb begin
        PrRD = 32'd0;
        if (hit0_s) begin
            PrRD = rd0_s;
        end else if (hit1_s) begin
            PrRD = rd1_s;
        end else begin
            PrRD = 32'd0;
        end
    end

    assign HWInt = {ext_int, irq1_s, irq0_s};

endmodule
